muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. Consumes the two register-file read operands (RD1/RD2) plus the destination index, runs a 32-iteration shift-add multiply or restoring divide, and presents a one-cycle registered write-back (result, destination, write enable) that drives the register file's WD3/A3/WE3 port. It sits in the execute stage beside the single-cycle ALU and stalls issue via BUSY.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, controller state encoding and iteration count.
package muldiv_pkg;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam int ITER_COUNT = 32;
endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring
// divide on sign-stripped magnitudes, one-cycle registered write-back.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            CLR,
   input  logic            START,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] OP_A,
   input  logic [XLEN-1:0] OP_B,
   input  logic [4:0]      RD_IN,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT,
   output logic [4:0]      RD_OUT,
   output logic            WE_OUT
);

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] result_q, result_d;

   logic        is_div;
   logic [32:0] add_a, add_b, sum;
   logic [63:0] step, prod_fix;
   logic [31:0] quot_fix, rem_fix, fin_res;
   logic        a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
   logic [31:0] a_mag, b_mag, special_res;

   // Shared 33-bit adder: multiply adds into the upper half, divide
   // trial-subtracts the divisor from the shifted-in remainder.
   always_comb begin
      is_div = f3_q[2];
      add_a  = is_div ? acc_q[63:31] : {1'b0, acc_q[63:32]};
      if (is_div)
         add_b = ~{1'b0, opb_q};
      else
         add_b = acc_q[0] ? {1'b0, opb_q} : 33'd0;
      sum = add_a + add_b + {32'd0, is_div};
      if (!is_div)
         step = {sum, acc_q[31:1]};
      else if (sum[32])
         step = {acc_q[62:0], 1'b0};
      else
         step = {sum[31:0], acc_q[30:0], 1'b1};
   end

   always_comb begin
      prod_fix = neg_q ? (~step + 64'd1) : step;
      quot_fix = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
      rem_fix  = rneg_q ? (~step[63:32] + 32'd1) : step[63:32];
      case (f3_q)
         F3_MUL:                     fin_res = prod_fix[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fin_res = prod_fix[63:32];
         F3_DIV, F3_DIVU:            fin_res = quot_fix;
         default:                    fin_res = rem_fix;
      endcase
   end

   always_comb begin
      a_signed = (FUNCT3 == F3_MUL) || (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU) ||
                 (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
      b_signed = (FUNCT3 == F3_MUL) || (FUNCT3 == F3_MULH) ||
                 (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
      a_neg    = a_signed && OP_A[31];
      b_neg    = b_signed && OP_B[31];
      a_mag    = a_neg ? (~OP_A + 32'd1) : OP_A;
      b_mag    = b_neg ? (~OP_B + 32'd1) : OP_B;
      div_zero = FUNCT3[2] && (OP_B == 32'd0);
      div_ovf  = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
                 (OP_A == 32'h8000_0000) && (OP_B == 32'hFFFF_FFFF);
      if (div_zero)
         special_res = FUNCT3[1] ? OP_A : 32'hFFFF_FFFF;
      else
         special_res = FUNCT3[1] ? 32'd0 : 32'h8000_0000;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               f3_d   = FUNCT3;
               rd_d   = RD_IN;
               neg_d  = a_neg ^ b_neg;
               rneg_d = a_neg;
               cnt_d  = 5'd0;
               acc_d  = {32'd0, a_mag};
               opb_d  = b_mag;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  state_d  = FIN;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER_COUNT - 1)) begin
               result_d = fin_res;
               state_d  = FIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         f3_q     <= 3'd0;
         rd_q     <= 5'd0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         acc_q    <= 64'd0;
         opb_q    <= 32'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         result_q <= result_d;
      end
   end

   assign BUSY   = (state_q != IDLE);
   assign DONE   = (state_q == FIN);
   assign RESULT = result_q;
   assign RD_OUT = rd_q;
   assign WE_OUT = DONE && (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected write-backs,
// a monitor pops and compares on every DONE.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        CLR, START;
   logic [2:0]  FUNCT3;
   logic [31:0] OP_A, OP_B;
   logic [4:0]  RD_IN;
   logic        BUSY, DONE, WE_OUT;
   logic [31:0] RESULT;
   logic [4:0]  RD_OUT;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
      int          done_cyc;
      logic [2:0]  f3;
   } exp_t;
   exp_t sb_q[$];

   muldiv_unit #(.XLEN(32)) dut (
      .CLK(clk), .CLR(CLR), .START(START), .FUNCT3(FUNCT3),
      .OP_A(OP_A), .OP_B(OP_B), .RD_IN(RD_IN),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RD_OUT(RD_OUT), .WE_OUT(WE_OUT)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, expv);
      end
   endtask

   // Reference semantics straight from the RV32M definitions.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (f3)
         F3_MUL:    begin p = sa * sb; return p[31:0];  end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * ub; return p[63:32]; end
         F3_MULHU:  begin p = ua * ub; return p[63:32]; end
         F3_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = sa / sb; return q[31:0];
         end
         F3_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            q = ua / ub; return q[31:0];
         end
         F3_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            q = sa % sb; return q[31:0];
         end
         default: begin
            if (b == 0) return a;
            q = ua % ub; return q[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return 1;
      return 33;
   endfunction

   // Waits (bounded) for an idle cycle, presents START for one cycle;
   // returns at the negedge after the capture edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit push);
      int t = 0;
      exp_t e;
      while (BUSY && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("idle_timeout", 64'(BUSY), 64'd0);
      START = 1'b1; FUNCT3 = f3; OP_A = a; OP_B = b; RD_IN = rd;
      if (push) begin
         e.res = ref_model(f3, a, b);
         e.rd = rd;
         e.we = (rd != 0);
         e.done_cyc = cyc + ref_latency(f3, a, b);
         e.f3 = f3;
         sb_q.push_back(e);
      end
      @(negedge clk);
      START = 1'b0;
      OP_A = $urandom; OP_B = $urandom; FUNCT3 = 3'($urandom); RD_IN = 5'($urandom);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (DONE) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", {32'd0, RESULT}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               $display("txn f3=%0d result=%h rd=%0d we=%0d cyc=%0d", e.f3, RESULT, RD_OUT,
                        WE_OUT, cyc);
               chk("result", 64'(RESULT), 64'(e.res));
               chk("rd_out", 64'(RD_OUT), 64'(e.rd));
               chk("we_out", 64'(WE_OUT), 64'(e.we));
               chk("latency", 64'(cyc), 64'(e.done_cyc));
            end
         end
      end
   end

   initial begin : stim
      int t;
      logic [2:0]  f3;
      logic [31:0] a, b;
      CLR = 1'b1; START = 1'b0; FUNCT3 = 3'd0; OP_A = 32'd0; OP_B = 32'd0; RD_IN = 5'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_done", 64'(DONE), 64'd0);
      chk("rst_we", 64'(WE_OUT), 64'd0);
      chk("rst_result", 64'(RESULT), 64'd0);
      chk("rst_rd", 64'(RD_OUT), 64'd0);
      CLR = 1'b0;

      issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1);
      issue(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1);
      issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1);
      issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1);
      issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1);
      issue(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 1);
      issue(F3_DIVU, 32'd100, 32'd7, 5'd7, 1);
      issue(F3_REMU, 32'd100, 32'd7, 5'd8, 1);
      issue(F3_DIVU, 32'd5, 32'd0, 5'd9, 1);
      issue(F3_REM, 32'd5, 32'd0, 5'd10, 1);
      issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1);
      issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);

      // Stray START pulses while busy (cycles 1, 10, 33) must be dropped.
      issue(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1);
      for (int k = 1; k <= 33; k++) begin
         if (k > 1) @(negedge clk);
         START = (k == 1 || k == 10 || k == 33);
         FUNCT3 = F3_DIVU; OP_A = $urandom; OP_B = 32'd0; RD_IN = 5'd31;
      end
      @(negedge clk);
      START = 1'b0;

      issue(F3_MUL, 32'd9, 32'd9, 5'd0, 1);

      // Abort at iteration 20, then restart immediately.
      issue(F3_DIV, 32'd1000, 32'd3, 5'd14, 0);
      repeat (19) @(negedge clk);
      CLR = 1'b1;
      @(negedge clk);
      chk("clr_busy", 64'(BUSY), 64'd0);
      chk("clr_done", 64'(DONE), 64'd0);
      chk("clr_we", 64'(WE_OUT), 64'd0);
      CLR = 1'b0;
      issue(F3_MUL, 32'd3, 32'd4, 5'd15, 1);

      // CLR and START on the same edge: CLR wins.
      t = 0;
      while (BUSY && t < 100) begin
         @(negedge clk);
         t++;
      end
      CLR = 1'b1; START = 1'b1; FUNCT3 = F3_MUL; OP_A = 32'd1; OP_B = 32'd1; RD_IN = 5'd1;
      @(negedge clk);
      chk("clr_start_busy", 64'(BUSY), 64'd0);
      CLR = 1'b0; START = 1'b0;

      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         issue(f3, a, b, 5'($urandom_range(0, 31)), 1);
      end

      t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
